// File: rtl/gpr_pkg.sv
// Shared types for the GPR write-back queue.
// Entry bundle and register-file widths.
package gpr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match bypass search over the pending
// write-back entries of the ring buffer.
module wb_fwd_match
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    ent_i [DEPTH],
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [$clog2(DEPTH)-1:0]     tail_i,
  input  logic [REG_ADDR_W-1:0]        key_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Oldest first, so the youngest match is the last assignment.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = tail_i - PW'(i) - PW'(1);
      if (key_i != '0 && vld_i[idx] &&
          ent_i[idx].dest == key_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/gpr_wb_queue.sv
// Buffered register-file write-back queue with
// youngest-entry operand bypass on rs/rt.
module gpr_wb_queue
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_dest,
  input  logic [31:0]                  in_data,
  input  logic                         wb_stall,
  output logic                         reg_write,
  output logic [4:0]                   num_write,
  output logic [31:0]                  data_write,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  output logic                         fwd_a_hit,
  output logic                         fwd_b_hit,
  output logic [31:0]                  fwd_a,
  output logic [31:0]                  fwd_b,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    offs;
  wb_entry_t        head_ent;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = reset_n && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // x0 writes finish the handshake but never occupy a slot.
  assign push     = accept && (in_dest != '0);
  assign pop      = reg_write;

  assign head_ent   = mem_q[head_q];
  assign reg_write  = !empty && !wb_stall;
  assign num_write  = empty ? '0 : head_ent.dest;
  assign data_write = empty ? '0 : head_ent.data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage payload is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= '{dest: in_dest, data: in_data};
    end
  end

  always_comb begin
    vld  = '0;
    offs = '0;
    for (int s = 0; s < DEPTH; s++) begin
      offs   = PW'(s) - head_q;
      vld[s] = (CW'(offs) < count_q);
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_match_a (
    .ent_i  (mem_q),
    .vld_i  (vld),
    .tail_i (tail_q),
    .key_i  (rs),
    .hit_o  (fwd_a_hit),
    .data_o (fwd_a)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_match_b (
    .ent_i  (mem_q),
    .vld_i  (vld),
    .tail_i (tail_q),
    .key_i  (rt),
    .hit_o  (fwd_b_hit),
    .data_o (fwd_b)
  );

endmodule

// File: doc/gpr_wb_queue.md
GPR_WB_QUEUE -- requirements
Module: gpr_wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of buffered write-back entries, a power of two, at least 2.
REQ-002 The block SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1: the producer offers a write-back entry.
REQ-005 The block SHALL have port in_ready, output, 1: the block can accept an entry this cycle.
REQ-006 The block SHALL have port in_dest, input, 5: destination register number.
REQ-007 The block SHALL have port in_data, input, 32: write-back data.
REQ-008 The block SHALL have port wb_stall, input, 1: hold the register-file write port idle this cycle.
REQ-009 The block SHALL have port reg_write, output, 1: register-file write enable.
REQ-010 The block SHALL have port num_write, output, 5: register-file write address.
REQ-011 The block SHALL have port data_write, output, 32: register-file write data.
REQ-012 The block SHALL have ports rs and rt, input, 5 each: operand register numbers for the bypass lookup.
REQ-013 The block SHALL have ports fwd_a_hit and fwd_b_hit, output, 1 each: a pending entry matches rs or rt respectively.
REQ-014 The block SHALL have ports fwd_a and fwd_b, output, 32 each: the bypass data for rs and rt.
REQ-015 The block SHALL have port count, output, clog2(DEPTH+1): the number of pending entries.
REQ-016 The block SHALL have port empty, output, 1: count equals 0.

Function
REQ-017 The block SHALL drive in_ready = (count < DEPTH); in_ready SHALL NOT depend on a same-cycle pop.
REQ-018 The block SHALL treat in_valid && in_ready at a rising edge as an accepted entry.
REQ-019 The block SHALL store an accepted entry at the tail, except that an entry with in_dest == 0 SHALL complete the handshake and be discarded.
REQ-020 The block SHALL drive reg_write = !empty && !wb_stall combinationally, with num_write and data_write taken from the head entry.
REQ-021 The block SHALL pop the head at each rising edge where reg_write is 1.
REQ-022 The block SHALL make an entry accepted at edge N visible on the write port during the following cycle and commit it at edge N+1, given an empty queue and no stall.
REQ-023 The block SHALL perform a simultaneous push and pop in one edge, leaving count unchanged.
REQ-024 The block SHALL wrap its head and tail pointers modulo DEPTH.
REQ-025 The block SHALL force num_write and data_write to 0 when empty.
REQ-026 The block SHALL assert fwd_a_hit when rs != 0 and any pending entry, including the head, has dest == rs.
REQ-027 The block SHALL drive fwd_a from the youngest matching entry.
REQ-028 The block SHALL drive fwd_a_hit = 0 and fwd_a = 0 when there is no match or rs == 0.
REQ-029 The block SHALL compute fwd_b and fwd_b_hit from rt identically to fwd_a and fwd_a_hit.
REQ-030 The block SHALL exclude same-cycle in_data from the bypass lookup.

Reset
REQ-031 The block SHALL, while reset_n is 0, asynchronously clear its pointers and count and discard all pending entries.
REQ-032 The block SHALL, while reset_n is 0, drive reg_write = 0, num_write = 0, data_write = 0, fwd_* = 0, count = 0, empty = 1 and in_ready = 0.
REQ-033 The block SHALL drive in_ready = 1 from the first cycle after reset_n deasserts.
REQ-034 The block SHALL lose pending writes on a reset asserted mid-operation, with no partial register-file write.
REQ-035 The block SHALL NOT reset storage data.

Structure
REQ-036 Package gpr_pkg SHALL hold REG_ADDR_W=5, DATA_W=32 and the typedef wb_entry_t {dest, data}.
REQ-037 The block SHALL use one sub-module, wb_fwd_match: a combinational youngest-match priority search over the valid entries, instantiated twice (rs and rt).

Verification
REQ-038 The bench SHALL push {dest 3, data 0x11223344} into an empty queue with no stall -> reg_write=1, num_write=3, data_write=0x11223344 the next cycle, then empty=1.
REQ-039 The bench SHALL hold wb_stall=1 and push 4 entries -> count=4 and in_ready=0; a 5th offered entry is not accepted; release the stall -> 4 writes in FIFO order on consecutive cycles.
REQ-040 The bench SHALL push {dest 0, data 0xFFFFFFFF} -> the handshake completes, count stays 0 and reg_write stays 0.
REQ-041 The bench SHALL, under stall, push {5, 0xA}, {5, 0xB} with rs=5, rt=0 -> fwd_a_hit=1, fwd_a=0xB, fwd_b_hit=0, fwd_b=0.
REQ-042 The bench SHALL push and pop simultaneously at count=2 for 10 cycles -> count stays 2, pointers wrap, and data order is preserved.
REQ-043 The bench SHALL assert reset_n=0 mid-cycle with count=3 -> reg_write=0 and count=0 immediately, with no register-file write at the next edge.
